// File: rtl/rom_load_ctrl.sv
// ROM download sequencer: forwards the HPS ioctl byte stream to the core's
// dn_* port, validates the byte count and address range, and owns the core
// reset. The core stays in reset during the download and for a settle period
// after it. After a bad load the core is held in reset until a new download.
module rom_load_ctrl #(
  parameter int unsigned EXP_BYTES     = 25120,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned MIN_RST       = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        user_rst,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_err
);

  localparam int unsigned CNT_W = 17;
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned PUL_W = $clog2(MIN_RST + 1);

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_EXP     = CNT_W'(EXP_BYTES);
  localparam logic [24:0]      ADDR_LIMIT  = 25'(EXP_BYTES);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [PUL_W-1:0] PULSE_LOAD  = PUL_W'(MIN_RST - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN,
    HALT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             ovf_q, ovf_d;
  logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [PUL_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic             load_done_q, load_done_d;
  logic             load_err_q, load_err_d;
  logic             core_reset_q, core_reset_d;
  logic             dl_q;

  logic in_range;
  logic fwd;
  logic dl_rise;
  logic start_dl;
  logic pulse_start;

  assign in_range = ioctl_addr < ADDR_LIMIT;
  assign fwd      = (state_q == LOAD) && ioctl_wr && in_range;
  assign dl_rise  = ioctl_download && !dl_q;

  // IDLE starts on the download level so a download still high after RESET
  // re-enters LOAD; elsewhere only a fresh rising edge restarts.
  assign start_dl = (state_q == IDLE) ? ioctl_download
                                      : ((state_q != LOAD) && dl_rise);

  // A user reset request starts the minimum-width timer only when the core is
  // running; a request held longer than the timer keeps core_reset high by level.
  assign pulse_start = user_rst && !core_reset_q;

  // State and control registers.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RESET) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      settle_cnt_q <= '0;
      pulse_cnt_q  <= '0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      core_reset_q <= 1'b1;
      dl_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      ovf_q        <= ovf_d;
      settle_cnt_q <= settle_cnt_d;
      pulse_cnt_q  <= pulse_cnt_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
      core_reset_q <= core_reset_d;
      dl_q         <= ioctl_download;
    end
  end

  // Next-state, counters, status flags and the next core_reset level.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    ovf_d        = ovf_q;
    settle_cnt_d = settle_cnt_q;
    pulse_cnt_d  = pulse_cnt_q;
    load_done_d  = load_done_q;
    load_err_d   = load_err_q;
    core_reset_d = 1'b1;

    if (start_dl) begin
      // Download start wins over settle completion and user reset requests.
      state_d      = LOAD;
      byte_cnt_d   = '0;
      ovf_d        = 1'b0;
      settle_cnt_d = '0;
      pulse_cnt_d  = '0;
      load_done_d  = 1'b0;
      load_err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;

        LOAD: begin
          // A strobe on the same cycle the download drops is counted first.
          if (ioctl_wr) begin
            if (byte_cnt_q != CNT_MAX) byte_cnt_d = byte_cnt_q + CNT_W'(1);
            if (!in_range)             ovf_d      = 1'b1;
          end
          if (!ioctl_download) begin
            if ((byte_cnt_d == CNT_EXP) && !ovf_d) begin
              state_d      = SETTLE;
              settle_cnt_d = '0;
            end else begin
              state_d    = HALT;
              load_err_d = 1'b1;
            end
          end
        end

        SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d      = RUN;
            load_done_d  = 1'b1;
            core_reset_d = 1'b0;
          end else begin
            settle_cnt_d = settle_cnt_q + SET_W'(1);
          end
        end

        RUN: begin
          if (pulse_start) begin
            pulse_cnt_d = PULSE_LOAD;
          end else if (pulse_cnt_q != '0) begin
            pulse_cnt_d = pulse_cnt_q - PUL_W'(1);
          end
          core_reset_d = user_rst || (pulse_cnt_q != '0);
        end

        HALT: ;

        default: state_d = IDLE;
      endcase
    end
  end

  // Registered download port: one-cycle latency from an in-range ioctl_wr.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dn_wr   <= 1'b0;
      dn_addr <= '0;
      dn_data <= '0;
    end else begin
      dn_wr <= fwd;
      if (fwd) begin
        dn_addr <= ioctl_addr[15:0];
        dn_data <= ioctl_dout;
      end
    end
  end

  assign core_reset = core_reset_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Bench for rom_load_ctrl. Forwarded writes are checked by a scoreboard:
// each in-range byte pushes its expected dn_addr/dn_data and arrival cycle,
// and a monitor pops and compares whenever dn_wr is seen. Reset, settle,
// user-reset and status behaviour are checked inline by the stimulus.
// The expected byte count is shortened so the run stays short; the settle
// and minimum-reset lengths keep their default values.
module tb_rom_load_ctrl;

  localparam int EXP    = 2512;
  localparam int SETTLE = 1024;
  localparam int MINR   = 16;

  logic        CLK;
  logic        RESET;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        user_rst;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        core_reset;
  logic        load_done;
  logic        load_err;

  rom_load_ctrl #(
    .EXP_BYTES    (EXP),
    .SETTLE_CYCLES(SETTLE),
    .MIN_RST      (MINR)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .user_rst      (user_rst),
    .dn_addr       (dn_addr),
    .dn_data       (dn_data),
    .dn_wr         (dn_wr),
    .core_reset    (core_reset),
    .load_done     (load_done),
    .load_err      (load_err)
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Cycle stamp used to verify the one-cycle forwarding latency.
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int a);
    return 8'(a * 13 + 7);
  endfunction

  // Monitor: every dn_wr must match the oldest expected write, on its cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (dn_wr) begin
      if (sb.size() == 0) begin
        check("spurious_dn_wr", dn_wr, 1'b0);
      end else begin
        e = sb.pop_front();
        check("dn_write", {8'h0, cyc, dn_addr, dn_data}, {8'h0, e.cyc, e.addr, e.data});
      end
    end
  end

  // One ioctl strobe; in-range bytes are expected on dn_* one cycle later.
  task automatic send_byte(input int a, input logic [7:0] d);
    exp_t e;
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    if (a < EXP) begin
      e.addr = 16'(a);
      e.data = d;
      e.cyc  = cyc + 1;
      sb.push_back(e);
    end
    @(negedge CLK);
    ioctl_wr = 1'b0;
  endtask

  task automatic stream(input int first, input int last);
    for (int a = first; a <= last; a++) send_byte(a, pat(a));
  endtask

  task automatic start_download();
    ioctl_download = 1'b1;
    @(negedge CLK);
  endtask

  task automatic end_download();
    ioctl_download = 1'b0;
    @(negedge CLK);
  endtask

  // Called on the first sample after the download fall has been clocked in.
  task automatic measure_settle(input string name);
    int n = 0;
    while (core_reset && n < 5000) begin
      n++;
      @(negedge CLK);
    end
    check(name, n, SETTLE);
  endtask

  // Holds user_rst for len cycles and counts cycles of core_reset high.
  task automatic user_pulse(input int len, input int exp_len, input string name);
    int n = 0;
    user_rst = 1'b1;
    repeat (len) begin
      @(negedge CLK);
      if (core_reset) n++;
    end
    user_rst = 1'b0;
    repeat (60) begin
      @(negedge CLK);
      if (core_reset) n++;
    end
    check(name, n, exp_len);
    check({name, "_released"}, core_reset, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_core_reset"}, core_reset, 1'b1);
    check({tag, "_dn_wr"},      dn_wr,      1'b0);
    check({tag, "_dn_addr"},    dn_addr,    16'h0);
    check({tag, "_dn_data"},    dn_data,    8'h0);
    check({tag, "_load_done"},  load_done,  1'b0);
    check({tag, "_load_err"},   load_err,   1'b0);
  endtask

  initial begin
    int lows;
    RESET          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    user_rst       = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_values("por");
    RESET = 1'b0;
    @(negedge CLK);
    check("idle_core_reset", core_reset, 1'b1);

    // Good load; the last strobe coincides with the download fall.
    start_download();
    stream(0, EXP - 2);
    ioctl_download = 1'b0;
    send_byte(EXP - 1, pat(EXP - 1));
    measure_settle("settle_len_1");
    check("run1_core_reset", core_reset, 1'b0);
    check("run1_load_done",  load_done,  1'b1);
    check("run1_load_err",   load_err,   1'b0);

    // User reset in RUN: short request stretched to MINR, long one by level.
    user_pulse(3, MINR, "user_rst_short");
    user_pulse(40, 40, "user_rst_long");

    // Reload from RUN.
    start_download();
    check("reload_core_reset", core_reset, 1'b1);
    check("reload_load_done",  load_done,  1'b0);
    stream(0, EXP - 1);
    end_download();
    measure_settle("settle_len_2");
    check("run2_load_done",  load_done,  1'b1);
    check("run2_core_reset", core_reset, 1'b0);

    // Short load: one byte missing.
    start_download();
    stream(0, EXP - 2);
    end_download();
    check("short_load_err",   load_err,   1'b1);
    check("short_load_done",  load_done,  1'b0);
    check("short_core_reset", core_reset, 1'b1);
    lows     = 0;
    user_rst = 1'b1;
    repeat (100) begin
      @(negedge CLK);
      if (!core_reset) lows++;
    end
    user_rst = 1'b0;
    check("halt_ignores_user_rst", lows, 0);
    check("halt_err_sticky", load_err, 1'b1);

    // Overflow: full load plus one write far out of range.
    start_download();
    check("ovf_a_err_cleared", load_err, 1'b0);
    stream(0, EXP - 1);
    send_byte(32'h7000, 8'hA5);
    end_download();
    check("ovf_a_load_err",   load_err,   1'b1);
    check("ovf_a_core_reset", core_reset, 1'b1);

    // Overflow with an exact byte count: first out-of-range address.
    start_download();
    stream(0, EXP - 2);
    send_byte(EXP, 8'h3C);
    end_download();
    check("ovf_b_load_err",  load_err,  1'b1);
    check("ovf_b_load_done", load_done, 1'b0);

    // RESET partway through a load with the download still high.
    start_download();
    stream(0, 499);
    RESET = 1'b1;
    @(negedge CLK);
    check_reset_values("midload");
    RESET = 1'b0;
    @(negedge CLK);
    check("relaunch_core_reset", core_reset, 1'b1);
    stream(500, EXP - 1);
    end_download();
    check("partial_load_err",   load_err,   1'b1);
    check("partial_core_reset", core_reset, 1'b1);

    repeat (5) @(negedge CLK);
    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: actual running expected finished");
    $fatal(1, "simulation timed out");
  end

endmodule
